imm_extend_pipe: RTL and testbench

Registered, parametrised immediate generator for the decode stage of the pipelined kianv core. It accepts a 32-bit instruction word, an immediate-format select and a tag over a valid/ready handshake. It returns the XLEN-wide extended immediate one cycle later. A 2-entry skid buffer sustains full throughput while keeping in_ready registered. It adds XLEN=64, CSR zimm and shift-amount formats, and an error flag for unknown formats.

---
 rtl/imm_pkg.sv | 18 +
 rtl/imm_format_decode.sv | 44 ++++
 rtl/imm_extend_pipe.sv | 111 +++++++++++
 tb/tb_imm_extend_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-format select codes for the decode-stage immediate generator.
package imm_pkg;

  localparam int IMMSRC_W = 4;

  localparam logic [IMMSRC_W-1:0] IMMSRC_I   = 4'd0;
  localparam logic [IMMSRC_W-1:0] IMMSRC_S   = 4'd1;
  localparam logic [IMMSRC_W-1:0] IMMSRC_B   = 4'd2;
  localparam logic [IMMSRC_W-1:0] IMMSRC_J   = 4'd3;
  localparam logic [IMMSRC_W-1:0] IMMSRC_U   = 4'd4;
  localparam logic [IMMSRC_W-1:0] IMMSRC_Z   = 4'd5;
  localparam logic [IMMSRC_W-1:0] IMMSRC_SH  = 4'd6;
  localparam logic [IMMSRC_W-1:0] IMMSRC_CI  = 4'd8;
  localparam logic [IMMSRC_W-1:0] IMMSRC_CJ  = 4'd9;
  localparam logic [IMMSRC_W-1:0] IMMSRC_CB  = 4'd10;
  localparam logic [IMMSRC_W-1:0] IMMSRC_CIW = 4'd11;

endpackage

// File: rtl/imm_format_decode.sv
// Combinational immediate extraction and extension for all formats.
// Compressed formats (codes 8-11) exist only when KIANV_RVC_IMM_EN is defined.
module imm_format_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]         instr,
  input  logic [IMMSRC_W-1:0] immsrc,
  output logic [XLEN-1:0]     imm,
  output logic                err
);

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (immsrc)
      IMMSRC_I:  imm = XLEN'($signed(instr[31:20]));
      IMMSRC_S:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMMSRC_B:  imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMMSRC_J:  imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMMSRC_U:  imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMMSRC_Z:  imm = XLEN'(instr[19:15]);
      // RV64 shifts carry a 6-bit shamt; RV32 only 5
      IMMSRC_SH: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
`ifdef KIANV_RVC_IMM_EN
      IMMSRC_CI:  imm = XLEN'($signed({instr[12], instr[6:2]}));
      IMMSRC_CJ:  imm = XLEN'($signed({instr[12], instr[8], instr[10:9], instr[6], instr[7],
                                        instr[2], instr[11], instr[5:3], 1'b0}));
      IMMSRC_CB:  imm = XLEN'($signed({instr[12], instr[6:5], instr[2], instr[11:10],
                                        instr[4:3], 1'b0}));
      IMMSRC_CIW: imm = XLEN'({instr[10:7], instr[12:11], instr[5], instr[6], 2'b00});
`endif
      default:   err = 1'b1;
    endcase
  end

`ifndef KIANV_RVC_IMM_EN
  // Opcode bits only feed the compressed formats.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];
`endif

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator with valid/ready handshake and a one-entry skid buffer.
// Optional compressed formats are enabled by defining KIANV_RVC_IMM_EN.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [IMMSRC_W-1:0] immsrc,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     immext,
  output logic                out_err,
  output logic [TAG_W-1:0]    out_tag
);

  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic             out_err_q, out_err_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic             skid_err_q, skid_err_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic accept;
  logic out_free;

  imm_format_decode #(.XLEN(XLEN)) u_decode (
    .instr  (instr),
    .immsrc (immsrc),
    .imm    (dec_imm),
    .err    (dec_err)
  );

  // in_ready is taken straight from skid occupancy so it never depends on out_ready.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_err_d    = out_err_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_err_d   = skid_err_q;
    skid_tag_d   = skid_tag_q;

    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_err_d    = skid_err_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_err_d   = dec_err;
        out_tag_d   = in_tag;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_err_d   = dec_err;
      skid_tag_d   = in_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_err_q    <= 1'b0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_err_q   <= 1'b0;
      skid_tag_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_err_q    <= out_err_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_err_q   <= skid_err_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign immext    = out_imm_q;
  assign out_err   = out_err_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share one input stream.
module tb_imm_extend_pipe;
  import imm_pkg::*;

  typedef struct {
    logic [63:0] imm;
    logic        err;
    logic [4:0]  tag;
  } exp_t;

  typedef struct {
    logic [31:0] i;
    logic [3:0]  s;
    logic [63:0] e32;
    logic [63:0] e64;
    logic        er;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [31:0] instr;
  logic [3:0]  immsrc;
  logic [4:0]  in_tag;

  logic        in_ready32, in_ready64, ov32, ov64, err32, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;

  int   checks = 0;
  int   failures = 0;
  int   nout32 = 0;
  int   nout64 = 0;
  exp_t q32[$];
  exp_t q64[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(ov32),
    .out_ready(out_ready), .immext(imm32), .out_err(err32), .out_tag(tag32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(ov64),
    .out_ready(out_ready), .immext(imm64), .out_err(err64), .out_tag(tag64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid&&ready at the falling edge.
  initial begin : monitor
    logic        held32, held64;
    logic [31:0] s_imm32;
    logic [63:0] s_imm64;
    logic [5:0]  s_et32, s_et64;
    exp_t        e;
    held32 = 1'b0;
    held64 = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held32 = 1'b0;
        held64 = 1'b0;
      end else begin
        if (held32 && ov32) begin
          check("stall_stable_imm32", imm32, s_imm32);
          check("stall_stable_errtag32", {err32, tag32}, s_et32);
        end
        if (held64 && ov64) begin
          check("stall_stable_imm64", imm64, s_imm64);
          check("stall_stable_errtag64", {err64, tag64}, s_et64);
        end
        held32  = ov32 && !out_ready;
        held64  = ov64 && !out_ready;
        s_imm32 = imm32;
        s_imm64 = imm64;
        s_et32  = {err32, tag32};
        s_et64  = {err64, tag64};
        if (ov32 && out_ready) begin
          nout32++;
          if (q32.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_beat32: got tag %0d expected no beat", tag32);
          end else begin
            e = q32.pop_front();
            check("imm32", imm32, e.imm[31:0]);
            check("err32", err32, e.err);
            check("tag32", tag32, e.tag);
          end
        end
        if (ov64 && out_ready) begin
          nout64++;
          if (q64.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_beat64: got tag %0d expected no beat", tag64);
          end else begin
            e = q64.pop_front();
            check("imm64", imm64, e.imm);
            check("err64", err64, e.err);
            check("tag64", tag64, e.tag);
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] i, input logic [3:0] s, input logic [4:0] t,
                      input logic [63:0] e32, input logic [63:0] e64, input logic er,
                      output int waits);
    instr    = i;
    immsrc   = s;
    in_tag   = t;
    in_valid = 1'b1;
    waits    = 0;
    @(negedge clk);
    while (!in_ready32 && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready32) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 for tag %0d expected 1", t);
      in_valid = 1'b0;
    end else begin
      check("in_ready64_agree", in_ready64, 1'b1);
      q32.push_back('{e32, er, t});
      q64.push_back('{e64, er, t});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w;
    int wsum;
    int n32, n64;

    vecs[0]  = '{32'hFFF00093, IMMSRC_I,  64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE512E23, IMMSRC_S,  64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{32'hFE000EE3, IMMSRC_B,  64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3]  = '{32'h0080006F, IMMSRC_J,  64'h00000008, 64'h0000000000000008, 1'b0};
    vecs[4]  = '{32'hFFDFF06F, IMMSRC_J,  64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[5]  = '{32'h80000037, IMMSRC_U,  64'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[6]  = '{32'h12345037, IMMSRC_U,  64'h12345000, 64'h0000000012345000, 1'b0};
    vecs[7]  = '{32'h000F8073, IMMSRC_Z,  64'h0000001F, 64'h000000000000001F, 1'b0};
    vecs[8]  = '{32'h02F00013, IMMSRC_SH, 64'h0000000F, 64'h000000000000002F, 1'b0};
    vecs[9]  = '{32'hFFFFFFFF, 4'd7,      64'h0,        64'h0,                1'b1};
`ifdef KIANV_RVC_IMM_EN
    vecs[10] = '{32'h0000FFFF, 4'd8,      64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
`else
    vecs[10] = '{32'h0000FFFF, 4'd8,      64'h0,        64'h0,                1'b1};
`endif
    vecs[11] = '{32'hFFFFFFFF, 4'd15,     64'h0,        64'h0,                1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; immsrc = '0; in_tag = '0;
    #2;
    check("rst_out_valid", {ov32, ov64}, 2'b00);
    check("rst_in_ready", {in_ready32, in_ready64}, 2'b11);
    check("rst_immext", imm64 | {32'b0, imm32}, 64'h0);
    check("rst_err_tag", {err32, err64, tag32, tag64}, 12'h0);
    @(posedge clk); #3; reset = 1'b0;
    @(posedge clk); #1;

    // Directed formats, back to back at full rate.
    for (int k = 0; k < 12; k++)
      send(vecs[k].i, vecs[k].s, 5'(k + 1), vecs[k].e32, vecs[k].e64, vecs[k].er, w);
    repeat (3) @(posedge clk);
    #1;
    check("drain_directed", q32.size() + q64.size(), 0);

    // Backpressure: hold the consumer for three edges while four beats arrive.
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++)
          send({12'(k), 20'h00093}, IMMSRC_I, 5'(k), 64'(k), 64'(k), 1'b0, w);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        check("bp_in_ready32", in_ready32, 1'b0);
        check("bp_in_ready64", in_ready64, 1'b0);
        check("bp_held_tag", tag32, 5'd1);
        out_ready = 1'b1;
      end
    join

    // Full rate resumes: every beat accepted on its first cycle.
    wsum = 0;
    for (int k = 0; k < 6; k++) begin
      send({12'(12'hFF0 + k), 20'h00093}, IMMSRC_I, 5'(16 + k),
           64'hFFFFFFF0 + 64'(k), 64'hFFFFFFFFFFFFFFF0 + 64'(k), 1'b0, w);
      wsum += w;
    end
    check("full_rate_waits", wsum, 0);
    repeat (3) @(posedge clk);
    #1;
    check("drain_stream", q32.size() + q64.size(), 0);

    // Reset with the skid entry occupied.
    out_ready = 1'b0;
    send(32'h00100093, IMMSRC_I, 5'd20, 64'h1, 64'h1, 1'b0, w);
    send(32'h00200093, IMMSRC_I, 5'd21, 64'h2, 64'h2, 1'b0, w);
    #2;
    check("pre_rst_skid_full", in_ready32, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", {ov32, ov64}, 2'b00);
    check("midrst_in_ready", {in_ready32, in_ready64}, 2'b11);
    q32.delete();
    q64.delete();
    out_ready = 1'b1;
    @(posedge clk); #3; reset = 1'b0;
    @(posedge clk); #1;
    n32 = nout32;
    n64 = nout64;
    send(32'h000F8073, IMMSRC_Z, 5'd22, 64'h1F, 64'h1F, 1'b0, w);
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_beats32", nout32 - n32, 1);
    check("post_rst_beats64", nout64 - n64, 1);
    check("final_drain", q32.size() + q64.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
